// File: rtl/data_memory_ws_if.sv
// Request/response bus between the CPU datapath and the wait-state data memory.
interface data_memory_ws_if;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] data_o;
  logic        ready_o;
  logic        busy_o;
  logic        err_o;

  modport master (output addr_i, data_i, MemRead_i, MemWrite_i,
                  input  data_o, ready_o, busy_o, err_o);
  modport slave  (input  addr_i, data_i, MemRead_i, MemWrite_i,
                  output data_o, ready_o, busy_o, err_o);
endinterface

// File: rtl/data_memory_ws.sv
// Wait-state data memory: one load or store at a time, completed LATENCY cycles
// after acceptance with a one-cycle ready pulse; malformed requests pulse err_o.
module data_memory_ws #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  data_memory_ws_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_write;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  logic [31:0]      r_data;
  logic             r_ready;
  logic             r_err;
  logic [31:0]      memory [DEPTH];

  logic w_req;
  logic w_valid;
  logic w_accept;
  logic w_reject;
  logic w_done;
  logic w_unused_addr;

  assign w_req    = bus.MemRead_i | bus.MemWrite_i;
  assign w_valid  = (bus.MemRead_i ^ bus.MemWrite_i) && (bus.addr_i[1:0] == 2'b00);
  assign w_accept = (r_state == IDLE) && w_valid;
  assign w_reject = (r_state == IDLE) && w_req && !w_valid;
  assign w_done   = (r_state == BUSY) && (r_cnt == '0);

  // Address bits above the word index are ignored so addresses wrap onto the array.
  assign w_unused_addr = ^bus.addr_i[31:IDX_W+2];

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path through this block infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = BUSY;
      BUSY:    if (w_done)   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.busy_o  = (r_state == BUSY);
    bus.ready_o = r_ready;
    bus.err_o   = r_err;
    bus.data_o  = r_data;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt      <= '0;
      r_is_write <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_data     <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ready <= w_done;
      r_err   <= w_reject;
      if (w_accept) begin
        r_cnt      <= CNT_W'(LATENCY - 1);
        r_is_write <= bus.MemWrite_i;
        r_idx      <= bus.addr_i[IDX_W+1:2];
        r_wdata    <= bus.data_i;
      end else if ((r_state == BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_done && !r_is_write) r_data <= memory[r_idx];
    end
  end

  // NOTE: the storage array is cleared by reset, so it is built from flops
  // rather than a RAM macro; an aborted store never reaches it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) memory[i] <= '0;
    end else if (w_done && r_is_write) begin
      memory[r_idx] <= r_wdata;
    end
  end
endmodule

// File: doc/data_memory_ws.md
Name: data_memory_ws

Overview:
- Wait-state data memory for the single-cycle CPU datapath; sits downstream of the ALU address path and upstream of the register write-back mux.
- Accepts one load or store at a time and completes it after a fixed, parameterised latency, signalling completion with a one-cycle ready pulse.
- The CPU stalls on busy_o. This block replaces the zero-latency data memory for multi-cycle and stall testing.

Parameters:
- DEPTH, 32, number of 32-bit words; power of two, 2..256.
- LATENCY, 3, cycles from request acceptance to completion; at least 1.

Ports:
- clk_i  input  1  system clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous active-low reset; 0 resets the block immediately, independent of clk_i.
- addr_i  input  32  byte address; word index is addr_i[log2(DEPTH)+1:2].
- data_i  input  32  store data.
- MemRead_i  input  1  load request.
- MemWrite_i  input  1  store request.
- data_o  output  32  load result.
- ready_o  output  1  one-cycle pulse at completion of an access.
- busy_o  output  1  high while an access is in flight.
- err_o  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (rst_i=0):
  - state=IDLE, latency counter=0.
  - data_o=0, ready_o=0, busy_o=0, err_o=0.
  - All DEPTH words cleared to 0.
  - Storage array is named memory[0..DEPTH-1] so benches can probe it hierarchically.
- Reset mid-access aborts the access. A pending store is not committed and no ready_o pulse is produced.
- States:
  - IDLE: no access in flight.
  - BUSY: access in flight.
- IDLE, rising edge, request evaluation:
  - Valid request: exactly one of MemRead_i or MemWrite_i is high and addr_i[1:0]=00.
    - Latch op, word index, and data_i.
    - Load counter with LATENCY-1.
    - busy_o=1, go to BUSY.
  - Both MemRead_i and MemWrite_i high, or addr_i[1:0]!=00 with either request high:
    - err_o=1 for one cycle.
    - Stay in IDLE; no memory or data_o change.
  - Neither request high: remain in IDLE.
- BUSY, each rising edge:
  - If counter!=0: decrement. Input changes are ignored; latched values are used.
  - If counter==0: complete the access.
    - Load: data_o <= memory[idx].
    - Store: memory[idx] <= latched data.
    - ready_o=1 for exactly this cycle, busy_o=0, return to IDLE.
- Latency:
  - Accepted at edge k, completion at edge k+LATENCY.
  - LATENCY=1 gives ready_o one cycle after acceptance.
- data_o holds the last load result. Stores and errors never change it.
- Back-to-back: a request held during the ready_o cycle is accepted at the next edge. There are no idle bubbles beyond that edge.
- Address wrap: address bits above the index field are ignored, so address DEPTH*4 aliases word 0.
- ready_o and err_o are never high in the same cycle. busy_o and ready_o are never high in the same cycle.
- Store then load to the same word returns the stored value; there is no bypass or forwarding path.

Test Plan:
1. Reset then idle: rst_i=0 for 2 cycles, release, no requests for 5 cycles -> data_o=0, ready_o/busy_o/err_o stay 0, memory[0..31]=0.
2. Store/load, LATENCY=3:
   - Store 32'd25 to addr 8 -> busy_o high for 3 cycles, ready_o pulses at edge 3, memory[2]=25.
   - Then load addr 8 -> ready_o at edge 3, data_o=25.
3. Back-to-back with LATENCY=1: stores of 1,2,3 to addrs 0,4,8, each request held through its ready cycle -> three ready pulses on alternate cycles, memory[0..2]=1,2,3.
4. Error cases:
   - Load at addr 6 -> err_o single pulse, busy_o stays 0, data_o unchanged.
   - MemRead_i and MemWrite_i both high at addr 4 -> err_o pulse, memory[1] unchanged.
5. Input change during BUSY: accept store 77 to addr 12, then change data_i to 99 and addr_i to 16 while busy -> memory[3]=77, memory[4] unchanged.
6. Reset mid-access: store 55 to addr 20, assert rst_i=0 one cycle after acceptance -> busy_o=0 immediately, no ready_o, memory[5]=0. Wrap check: store 9 to addr 128 -> memory[0]=9.
